mono_mode_ctrl: RTL and testbench

Control stage that drives the 2-bit `monochrome_switcher` select for the video output luma filter: green, amber, white or colour pass-through. It accepts mode changes from a CPU I/O port and from a keyboard hotkey pulse. It defers every change to the next vertical-sync leading edge so a frame never switches palette mid-scan, and it rate-limits hotkey cycling by a frame-counted hold-off. It sits in the `clk_vga` domain between the I/O decode / keyboard logic and the RGB output mixer.

---
 rtl/video_pkg.sv | 8 +
 rtl/vsync_edge_det.sv | 22 ++
 rtl/mono_mode_ctrl.sv | 70 +++++++
 tb/tb_mono_mode_ctrl.sv | 126 ++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// video_pkg: mode encodings and controller state shared by the video output blocks
package video_pkg;
  localparam logic [1:0] MODE_COLOUR = 2'b00;
  localparam logic [1:0] MODE_GREEN  = 2'b01;
  localparam logic [1:0] MODE_AMBER  = 2'b10;
  localparam logic [1:0] MODE_WHITE  = 2'b11;
  typedef enum logic {ST_IDLE, ST_PENDING} state_t;
endpackage

// File: rtl/vsync_edge_det.sv
// vsync_edge_det: one-cycle pulse on the leading edge of vertical sync
module vsync_edge_det #(
  parameter logic ACTIVE = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic vsync_i,
  output logic edge_o
);
  logic vs_q, armed_q;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vs_q    <= ~ACTIVE;
      armed_q <= 1'b0;
    end else begin
      vs_q    <= vsync_i;
      armed_q <= armed_q | (vsync_i != ACTIVE);
    end
  end
  // armed_q masks a sync already in progress when reset is released
  assign edge_o = armed_q && (vsync_i == ACTIVE) && (vs_q != ACTIVE);
endmodule

// File: rtl/mono_mode_ctrl.sv
// mono_mode_ctrl: monochrome palette select, changes deferred to vsync, hotkey rate-limited
module mono_mode_ctrl
  import video_pkg::*;
#(
  parameter logic [15:0] PORT_ADDR      = 16'h03DF,
  parameter int          HOLDOFF_FRAMES = 15,
  parameter logic        VSYNC_ACTIVE   = 1'b0
) (
  input  logic        clk_vga,
  input  logic        rst_n,
  input  logic [15:0] io_addr,
  input  logic        io_wr,
  input  logic        io_rd,
  input  logic [7:0]  io_din,
  output logic [7:0]  io_dout,
  input  logic        hotkey,
  input  logic        vga_vsync,
  output logic [1:0]  monochrome_switcher,
  output logic        mode_pending
);
  state_t     st_q, st_d;
  logic [1:0] act_q, act_d, pend_q, pend_d;
  logic [7:0] ho_q, ho_d, dout_d;
  logic       vs_edge, wr_hit, rd_hit, hk_ok, unused_din;
  vsync_edge_det #(.ACTIVE(VSYNC_ACTIVE)) u_vs (
    .clk(clk_vga), .rst_n(rst_n), .vsync_i(vga_vsync), .edge_o(vs_edge)
  );
  assign wr_hit     = io_wr && (io_addr == PORT_ADDR);
  assign rd_hit     = io_rd && (io_addr == PORT_ADDR);
  assign hk_ok      = hotkey && !wr_hit && (ho_q == 8'd0);
  assign unused_din = ^io_din[6:2];
  always_ff @(posedge clk_vga) begin
    if (!rst_n) begin
      st_q    <= ST_IDLE;
      act_q   <= MODE_COLOUR;
      pend_q  <= MODE_COLOUR;
      ho_q    <= 8'd0;
      io_dout <= 8'h00;
    end else begin
      st_q    <= st_d;
      act_q   <= act_d;
      pend_q  <= pend_d;
      ho_q    <= ho_d;
      io_dout <= dout_d;
    end
  end
  // commit first, then let a same-cycle request override state and pending mode
  always_comb begin
    st_d   = st_q;
    act_d  = act_q;
    pend_d = pend_q;
    ho_d   = (vs_edge && ho_q != 8'd0) ? ho_q - 8'd1 : ho_q;
    dout_d = rd_hit ? {5'b0, st_q == ST_PENDING, act_q} : 8'h00;
    if (vs_edge && st_q == ST_PENDING) begin
      act_d = pend_q;
      st_d  = ST_IDLE;
    end
    if (wr_hit) begin
      act_d  = io_din[7] ? io_din[1:0] : act_d;
      pend_d = io_din[7] ? pend_q : io_din[1:0];
      st_d   = io_din[7] ? ST_IDLE : ST_PENDING;
    end else if (hk_ok) begin
      pend_d = ((st_q == ST_PENDING) ? pend_q : act_q) + 2'd1;
      st_d   = ST_PENDING;
      ho_d   = 8'(HOLDOFF_FRAMES);
    end
  end
  assign monochrome_switcher = act_q;
  assign mode_pending        = (st_q == ST_PENDING);
endmodule

// File: tb/tb_mono_mode_ctrl.sv
// tb_mono_mode_ctrl: directed checks of mode register, hotkey hold-off and vsync commit
module tb_mono_mode_ctrl;
  logic        clk_vga = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] io_addr = 16'h0000;
  logic        io_wr = 1'b0, io_rd = 1'b0, hotkey = 1'b0, vga_vsync = 1'b1;
  logic [7:0]  io_din = 8'h00, io_dout;
  logic [1:0]  monochrome_switcher;
  logic        mode_pending;
  int          n_chk = 0, n_fail = 0;
  mono_mode_ctrl dut (
    .clk_vga(clk_vga), .rst_n(rst_n), .io_addr(io_addr), .io_wr(io_wr),
    .io_rd(io_rd), .io_din(io_din), .io_dout(io_dout), .hotkey(hotkey),
    .vga_vsync(vga_vsync), .monochrome_switcher(monochrome_switcher),
    .mode_pending(mode_pending)
  );
  always #5 clk_vga = ~clk_vga;
  task automatic tick();
    @(posedge clk_vga);
    #1;
  endtask
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic state(input string tag, input logic [1:0] sw, input logic p);
    chk({tag, "_sw"}, {6'd0, monochrome_switcher}, {6'd0, sw});
    chk({tag, "_pend"}, {7'd0, mode_pending}, {7'd0, p});
  endtask
  task automatic wr(input logic [15:0] a, input logic [7:0] d, input logic hk);
    io_addr = a; io_din = d; io_wr = 1'b1; hotkey = hk;
    tick();
    io_wr = 1'b0; hotkey = 1'b0;
  endtask
  task automatic hk();
    hotkey = 1'b1;
    tick();
    hotkey = 1'b0;
  endtask
  task automatic rd(input string tag, input logic [7:0] exp);
    io_addr = 16'h03DF; io_rd = 1'b1;
    tick();
    io_rd = 1'b0;
    chk(tag, io_dout, exp);
  endtask
  task automatic frame();
    vga_vsync = 1'b0;
    tick();
    vga_vsync = 1'b1;
    tick();
  endtask
  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame();
  endtask
  initial begin
    tick(); tick();
    state("reset", 2'b00, 1'b0);
    chk("reset_dout", io_dout, 8'h00);
    rst_n = 1'b1;
    tick();
    wr(16'h03DF, 8'h02, 1'b0);
    state("defer_wr", 2'b00, 1'b1);
    vga_vsync = 1'b0;
    tick();
    state("defer_commit", 2'b10, 1'b0);
    wr(16'h03DF, 8'h01, 1'b0);
    tick(); tick();
    state("held_vsync", 2'b10, 1'b1);
    vga_vsync = 1'b1;
    tick();
    frame();
    state("held_release", 2'b01, 1'b0);
    wr(16'h03DF, 8'h83, 1'b0);
    state("imm_wr", 2'b11, 1'b0);
    rd("rd_imm", 8'h03);
    tick();
    chk("rd_idle", io_dout, 8'h00);
    wr(16'h03DE, 8'h80, 1'b0);
    state("wrong_addr", 2'b11, 1'b0);
    hk();
    state("hk1", 2'b11, 1'b1);
    rd("rd_hk1", 8'h07);
    frame();
    state("hk1_commit", 2'b00, 1'b0);
    frames(2);
    hk();
    state("hk_holdoff", 2'b00, 1'b0);
    frames(12);
    hk();
    state("hk_after15", 2'b00, 1'b1);
    rd("rd_hk2", 8'h04);
    frame();
    state("hk2_commit", 2'b01, 1'b0);
    frames(14);
    wr(16'h03DF, 8'h00, 1'b1);
    state("wr_hk", 2'b01, 1'b1);
    hk();
    frame();
    state("wr_hk_commit", 2'b01, 1'b0);
    frames(15);
    io_addr = 16'h03DF; io_din = 8'h02; io_wr = 1'b1; vga_vsync = 1'b0;
    tick();
    io_wr = 1'b0;
    state("wr_on_edge", 2'b01, 1'b1);
    vga_vsync = 1'b1;
    tick();
    frame();
    state("wr_on_edge_next", 2'b10, 1'b0);
    wr(16'h03DF, 8'h03, 1'b0);
    state("pre_reset", 2'b10, 1'b1);
    rst_n = 1'b0; vga_vsync = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    state("mid_reset", 2'b00, 1'b0);
    vga_vsync = 1'b1;
    tick();
    frame();
    state("post_reset_vs", 2'b00, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
